// File: rtl/text_scroller_pkg.sv
// Shared constants and state type for the text scroller.
package text_scroller_pkg;

  localparam int unsigned CHAR_W     = 6;
  localparam int unsigned GLYPH_COLS = 8;
  localparam int unsigned COL_W      = 8;
  localparam int unsigned SCAN_W     = $clog2(GLYPH_COLS);

  typedef enum logic {
    StEmpty,
    StRun
  } state_e;

endpackage

// File: rtl/text_scroller_if.sv
// Message append, charRom lookup and LED column scan signals of the text scroller.
interface text_scroller_if;

  logic                                    clear;
  logic                                    scroll_en;
  logic                                    char_valid;
  logic [text_scroller_pkg::CHAR_W-1:0]    char_data;
  logic                                    char_ready;
  logic [text_scroller_pkg::CHAR_W-1:0]    rom_face;
  logic [text_scroller_pkg::SCAN_W-1:0]    rom_index;
  logic [text_scroller_pkg::COL_W-1:0]     rom_col;
  logic [text_scroller_pkg::COL_W-1:0]     col_data;
  logic [text_scroller_pkg::SCAN_W-1:0]    col_sel;
  logic                                    col_strobe;

  modport master (
    output clear, scroll_en, char_valid, char_data, rom_col,
    input  char_ready, rom_face, rom_index, col_data, col_sel, col_strobe
  );

  modport slave (
    input  clear, scroll_en, char_valid, char_data, rom_col,
    output char_ready, rom_face, rom_index, col_data, col_sel, col_strobe
  );

endinterface

// File: rtl/text_scroller.sv
// Scrolling message sequencer: addresses charRom per scan column and registers the
// returned pixels for an 8-column LED matrix.
module text_scroller
  import text_scroller_pkg::*;
#(
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned SCROLL_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  text_scroller_if.slave  bus
);

  localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = AW + 4;
  localparam int unsigned FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  state_e               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        scroll_pos_q, scroll_pos_d;
  logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
  logic [SCAN_W-1:0]    scan_col_q;
  logic [COL_W-1:0]     col_data_q;
  logic [SCAN_W-1:0]    col_sel_q;
  logic                 col_strobe_q;
  logic [CHAR_W-1:0]    msg_buf [MSG_LEN];

  logic                 accept;
  logic                 frame_end;
  logic                 div_hit;
  logic [PW-1:0]        len_cols;
  logic [PW-1:0]        v_raw;
  logic [PW-1:0]        v_addr;
  logic                 unused_v_msb;

  assign bus.char_ready = (len_q != LW'(MSG_LEN));
  assign accept         = bus.char_valid && bus.char_ready && !bus.clear;
  assign frame_end      = (scan_col_q == SCAN_W'(GLYPH_COLS - 1));
  assign div_hit        = (frame_cnt_q == FW'(SCROLL_DIV - 1));

  // Message length in display columns; scroll_pos < len_cols and scan_col < 8 <= len_cols,
  // so one conditional subtract wraps the address.
  assign len_cols     = {len_q, 3'b000};
  assign v_raw        = scroll_pos_q + PW'(scan_col_q);
  assign v_addr       = (v_raw >= len_cols) ? (v_raw - len_cols) : v_raw;
  assign unused_v_msb = v_addr[PW-1];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StRun;
    end
  end

  // FSM outputs: charRom address
  always_comb begin
    bus.rom_face  = '0;
    bus.rom_index = scan_col_q;
    unique case (state_q)
      StEmpty: ;
      StRun: begin
        bus.rom_face  = msg_buf[v_addr[AW+2:3]];
        bus.rom_index = v_addr[2:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    scroll_pos_d = scroll_pos_q;
    frame_cnt_d  = frame_cnt_q;
    if (accept) begin
      len_d    = len_q + LW'(1);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    // The wrap test deliberately uses the pre-append length.
    if (frame_end) begin
      if (div_hit) begin
        frame_cnt_d = '0;
        if (bus.scroll_en && (state_q == StRun)) begin
          scroll_pos_d = (scroll_pos_q == len_cols - PW'(1)) ? '0 : scroll_pos_q + PW'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
    if (bus.clear) begin
      len_d        = '0;
      wr_ptr_d     = '0;
      scroll_pos_d = '0;
      frame_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      wr_ptr_q     <= '0;
      scroll_pos_q <= '0;
      frame_cnt_q  <= '0;
      scan_col_q   <= '0;
      col_data_q   <= '0;
      col_sel_q    <= '0;
      col_strobe_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      scroll_pos_q <= scroll_pos_d;
      frame_cnt_q  <= frame_cnt_d;
      scan_col_q   <= scan_col_q + SCAN_W'(1);
      col_data_q   <= (state_q == StRun) ? bus.rom_col : '0;
      col_sel_q    <= scan_col_q;
      col_strobe_q <= 1'b1;
    end
  end

  // Message storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      msg_buf[wr_ptr_q] <= bus.char_data;
    end
  end

  assign bus.col_data   = col_data_q;
  assign bus.col_sel    = col_sel_q;
  assign bus.col_strobe = col_strobe_q;

endmodule

// File: tb/tb_text_scroller.sv
// Bench for text_scroller: two instances (SCROLL_DIV 4 and 1) against a message-queue model.
module tb_text_scroller;
  import text_scroller_pkg::*;

  localparam int unsigned MSG_LEN = 16;
  localparam int unsigned DIV_A   = 4;
  localparam int unsigned DIV_B   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       scroll_en = 1'b0;
  logic       char_valid = 1'b0;
  logic [5:0] char_data = '0;

  always #5 clk = ~clk;

  text_scroller_if bus_a ();
  text_scroller_if bus_b ();

  assign bus_a.clear      = clear;
  assign bus_a.scroll_en  = scroll_en;
  assign bus_a.char_valid = char_valid;
  assign bus_a.char_data  = char_data;
  assign bus_a.rom_col    = {bus_a.rom_face[4:0], bus_a.rom_index};
  assign bus_b.clear      = clear;
  assign bus_b.scroll_en  = scroll_en;
  assign bus_b.char_valid = char_valid;
  assign bus_b.char_data  = char_data;
  assign bus_b.rom_col    = {bus_b.rom_face[4:0], bus_b.rom_index};

  text_scroller #(.MSG_LEN(MSG_LEN), .SCROLL_DIV(DIV_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  text_scroller #(.MSG_LEN(MSG_LEN), .SCROLL_DIV(DIV_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [5:0] obs_face   [2];
  logic [2:0] obs_index  [2];
  logic       obs_ready  [2];
  logic [7:0] obs_data   [2];
  logic [2:0] obs_sel    [2];
  logic       obs_strobe [2];

  assign obs_face[0]   = bus_a.rom_face;
  assign obs_face[1]   = bus_b.rom_face;
  assign obs_index[0]  = bus_a.rom_index;
  assign obs_index[1]  = bus_b.rom_index;
  assign obs_ready[0]  = bus_a.char_ready;
  assign obs_ready[1]  = bus_b.char_ready;
  assign obs_data[0]   = bus_a.col_data;
  assign obs_data[1]   = bus_b.col_data;
  assign obs_sel[0]    = bus_a.col_sel;
  assign obs_sel[1]    = bus_b.col_sel;
  assign obs_strobe[0] = bus_a.col_strobe;
  assign obs_strobe[1] = bus_b.col_strobe;

  // Model: message as a queue, scroll offset in display columns, frames since last step.
  logic [5:0] msg [$];
  int         pos [2];
  int         frames [2];
  int         col;
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic int div_of(input int i);
    return (i == 0) ? int'(DIV_A) : int'(DIV_B);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle();
    int         sz;
    int         v;
    bit         run;
    logic [5:0] face;
    logic [2:0] idx;
    logic [7:0] exp_data [2];
    sz  = msg.size();
    run = (sz > 0);
    for (int i = 0; i < 2; i++) begin
      if (run) begin
        v           = (pos[i] + col) % (8 * sz);
        face        = msg[v / 8];
        idx         = 3'(v % 8);
        exp_data[i] = {face[4:0], idx};
      end else begin
        face        = '0;
        idx         = 3'(col);
        exp_data[i] = 8'h00;
      end
      check_eq($sformatf("rom_face[%0d]", i), 32'(obs_face[i]), 32'(face));
      check_eq($sformatf("rom_index[%0d]", i), 32'(obs_index[i]), 32'(idx));
      check_eq($sformatf("char_ready[%0d]", i), 32'(obs_ready[i]), 32'(sz < int'(MSG_LEN)));
    end
    for (int i = 0; i < 2; i++) begin
      if (col == 7) begin
        frames[i]++;
        if (frames[i] == div_of(i)) begin
          frames[i] = 0;
          if (scroll_en && run) pos[i] = (pos[i] + 1) % (8 * sz);
        end
      end
    end
    if (clear) begin
      msg.delete();
      pos    = '{0, 0};
      frames = '{0, 0};
    end else if (char_valid && (sz < int'(MSG_LEN))) begin
      msg.push_back(char_data);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("col_data[%0d]", i), 32'(obs_data[i]), 32'(exp_data[i]));
      check_eq($sformatf("col_sel[%0d]", i), 32'(obs_sel[i]), 32'(col));
      check_eq($sformatf("col_strobe[%0d]", i), 32'(obs_strobe[i]), 32'd1);
    end
    col = (col + 1) % 8;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    clear      = 1'b0;
    char_valid = 1'b0;
    reset      = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_col_data[%0d]", i), 32'(obs_data[i]), 32'd0);
      check_eq($sformatf("rst_col_sel[%0d]", i), 32'(obs_sel[i]), 32'd0);
      check_eq($sformatf("rst_col_strobe[%0d]", i), 32'(obs_strobe[i]), 32'd0);
      check_eq($sformatf("rst_char_ready[%0d]", i), 32'(obs_ready[i]), 32'd1);
    end
    msg.delete();
    pos    = '{0, 0};
    frames = '{0, 0};
    col    = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic append(input logic [5:0] c);
    char_valid = 1'b1;
    char_data  = c;
    cycle();
    char_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Idle after reset: blank columns, strobe every cycle.
    do_reset();
    scroll_en = 1'b1;
    run_cycles(16);

    // Two chars, frozen scroll, then scrolling.
    do_reset();
    scroll_en = 1'b0;
    append(6'd2);
    append(6'd3);
    run_cycles(32);
    scroll_en = 1'b1;
    run_cycles(200);

    // Fill the buffer, then hammer a full buffer.
    do_reset();
    scroll_en = 1'b0;
    for (int k = 0; k < int'(MSG_LEN); k++) append(6'($urandom));
    char_valid = 1'b1;
    char_data  = 6'h3F;
    run_cycles(10);
    char_valid = 1'b0;
    scroll_en  = 1'b1;
    run_cycles(1100);

    // Clear colliding with an append mid-scroll, then a single char.
    while (col != 3) cycle();
    clear      = 1'b1;
    char_valid = 1'b1;
    char_data  = 6'd9;
    cycle();
    clear      = 1'b0;
    char_valid = 1'b0;
    run_cycles(16);
    append(6'd5);
    run_cycles(120);

    // Asynchronous reset mid-frame while scrolling.
    append(6'd7);
    run_cycles(40);
    while (col != 4) cycle();
    do_reset();
    run_cycles(16);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      char_valid = ($urandom_range(0, 3) == 0);
      char_data  = 6'($urandom);
      clear      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) scroll_en = ~scroll_en;
      cycle();
    end
    clear      = 1'b0;
    char_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
